// File: rtl/mcop_pkg.sv
// Shared types and constants for the multi-cycle op scheduler.
// The optional divide timeout is enabled by MCOP_DIV_TIMEOUT_EN.
package mcop_pkg;

    localparam int unsigned OP_W      = 4;
    localparam int unsigned RD_W      = 4;
    localparam int unsigned UOP_W     = 3;
    localparam int unsigned SRC_W     = 2;
    localparam int unsigned LAT_W     = 3;
    localparam int unsigned TMO_W     = 6;
    localparam int unsigned TMO_LIMIT = 40;

    localparam logic [2:0] IOP_MUL  = 3'b100;
    localparam logic [2:0] IOP_SMUL = 3'b101;
    localparam logic [2:0] IOP_UMUL = 3'b110;
    localparam logic [2:0] IOP_DIV  = 3'b111;

    localparam logic [1:0] FOP_FADD  = 2'b00;
    localparam logic [1:0] FOP_FMUL  = 2'b01;
    localparam logic [1:0] FOP_FADDH = 2'b10;
    localparam logic [1:0] FOP_FMULH = 2'b11;

    localparam int unsigned LAT_MUL   = 3;
    localparam int unsigned LAT_FADD  = 4;
    localparam int unsigned LAT_FMUL  = 5;
    localparam int unsigned LAT_FADDH = 2;
    localparam int unsigned LAT_FMULH = 3;

    localparam logic [SRC_W-1:0] SRC_INT = 2'b00;
    localparam logic [SRC_W-1:0] SRC_FPU = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [RD_W-1:0] rd;
        logic            dz;
    } mcop_req_t;

    // Counter preload: ISSUE and the final WAIT cycle account for two of the L cycles.
    function automatic logic [LAT_W-1:0] lat_load(input logic [OP_W-1:0] op);
        int unsigned lat;
        lat = LAT_MUL;
        if (op[3]) begin
            case (op[1:0])
                FOP_FADD:  lat = LAT_FADD;
                FOP_FMUL:  lat = LAT_FMUL;
                FOP_FADDH: lat = LAT_FADDH;
                default:   lat = LAT_FMULH;
            endcase
        end
        return LAT_W'(lat - 2);
    endfunction

endpackage

// File: rtl/mcop_lat_ctr.sv
// Loadable 3-bit down counter with a zero flag, used to time fixed-latency ops.
module mcop_lat_ctr
    import mcop_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [LAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - LAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/mcop_sched.sv
// Multi-cycle op scheduler: issues MUL/DIV/FPU ops, times completion, raises writeback.
// Define MCOP_DIV_TIMEOUT_EN to abort a divide that never reports done.
module mcop_sched
    import mcop_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OP_W-1:0]  req_op,
    input  logic [RD_W-1:0]  req_rd,
    input  logic             div_zero,
    input  logic             div_done,
    input  logic             flush,
    output logic             mul_start,
    output logic             div_start,
    output logic             fpu_start,
    output logic [UOP_W-1:0] unit_op,
    output logic             unit_abort,
    output logic             busy,
    output logic             wb_valid,
    output logic [RD_W-1:0]  wb_rd,
    output logic [SRC_W-1:0] wb_src,
    output logic             wb_err
);

    state_e            state_q, state_d;
    mcop_req_t         req_q, req_d;
    logic              err_q, err_d;
    logic              abort_q, abort_d;
    logic              busy_q, busy_d;
    logic              wb_valid_q, wb_valid_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic [SRC_W-1:0]  wb_src_q, wb_src_d;
    logic              wb_err_q, wb_err_d;

    logic              ctr_load, ctr_dec, ctr_zero;
    logic [LAT_W-1:0]  ctr_load_val;
    logic              is_fpu, is_div, is_mul, is_bad;

`ifdef MCOP_DIV_TIMEOUT_EN
    logic [TMO_W-1:0]  tmo_q, tmo_d;
`endif

    mcop_lat_ctr u_lat_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (ctr_load),
        .load_val (ctr_load_val),
        .dec      (ctr_dec),
        .zero_c   (ctr_zero)
    );

    // Classify the latched op; codes 000-011 are not multi-cycle and complete as errors.
    always_comb begin
        is_fpu = req_q.op[3];
        is_div = !is_fpu && (req_q.op[2:0] == IOP_DIV);
        is_mul = !is_fpu && req_q.op[2] && (req_q.op[2:0] != IOP_DIV);
        is_bad = (!is_fpu && !req_q.op[2]) || (is_div && req_q.dz);
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        err_d        = err_q;
        abort_d      = 1'b0;
        mul_start    = 1'b0;
        div_start    = 1'b0;
        fpu_start    = 1'b0;
        ctr_load     = 1'b0;
        ctr_dec      = 1'b0;
        ctr_load_val = lat_load(req_q.op);
`ifdef MCOP_DIV_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    req_d.op = req_op;
                    req_d.rd = req_rd;
                    req_d.dz = div_zero;
                    err_d    = 1'b0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (flush) begin
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (is_bad) begin
                    err_d   = 1'b1;
                    state_d = ST_WB;
                end else begin
                    mul_start = is_mul;
                    div_start = is_div;
                    fpu_start = is_fpu;
                    ctr_load  = !is_div;
`ifdef MCOP_DIV_TIMEOUT_EN
                    tmo_d     = '0;
`endif
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (is_div) begin
                    if (div_done) begin
                        state_d = ST_WB;
                    end
`ifdef MCOP_DIV_TIMEOUT_EN
                    else if (tmo_q == TMO_W'(TMO_LIMIT - 1)) begin
                        abort_d = 1'b1;
                        err_d   = 1'b1;
                        state_d = ST_WB;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
`endif
                end else if (ctr_zero) begin
                    state_d = ST_WB;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d     = (state_d != ST_IDLE);
        wb_valid_d = (state_d == ST_WB);
        wb_rd_d    = wb_valid_d ? req_d.rd : '0;
        wb_src_d   = wb_valid_d ? (req_d.op[3] ? SRC_FPU : SRC_INT) : '0;
        wb_err_d   = wb_valid_d && err_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_src_q   <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
            busy_q     <= busy_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_src_q   <= wb_src_d;
            wb_err_q   <= wb_err_d;
        end
    end

`ifdef MCOP_DIV_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign req_ready  = reset && (state_q == ST_IDLE) && !flush;
    assign unit_op    = req_q.op[UOP_W-1:0];
    assign unit_abort = abort_q;
    assign busy       = busy_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_src     = wb_src_q;
    assign wb_err     = wb_err_q;

endmodule

// File: tb/tb_mcop_sched.sv
// Self-checking bench for mcop_sched: directed scenarios plus randomized ops against a timing model.
module tb_mcop_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_op = 4'h0;
    logic [3:0] req_rd = 4'h0;
    logic       div_zero = 1'b0;
    logic       div_done = 1'b0;
    logic       flush = 1'b0;
    logic       mul_start, div_start, fpu_start;
    logic [2:0] unit_op;
    logic       unit_abort, busy, wb_valid, wb_err;
    logic [3:0] wb_rd;
    logic [1:0] wb_src;

    int checks = 0;
    int errors = 0;

    mcop_sched dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rd     (req_rd),
        .div_zero   (div_zero),
        .div_done   (div_done),
        .flush      (flush),
        .mul_start  (mul_start),
        .div_start  (div_start),
        .fpu_start  (fpu_start),
        .unit_op    (unit_op),
        .unit_abort (unit_abort),
        .busy       (busy),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_src     (wb_src),
        .wb_err     (wb_err)
    );

    always #5 clk = ~clk;

    // Reference: 0 = error completion, 1 = multiplier, 2 = divider, 3 = FPU.
    function automatic int model_class(input logic [3:0] op, input logic dz);
        if (op[3]) return 3;
        if (op[2:0] == 3'b111) return dz ? 0 : 2;
        if (op[2]) return 1;
        return 0;
    endfunction

    function automatic int model_lat(input logic [3:0] op);
        if (!op[3]) return 3;
        case (op[1:0])
            2'b00:   return 4;
            2'b01:   return 5;
            2'b10:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one op in cycle 0 and check every cycle through the return to IDLE.
    task automatic run_op(input logic [3:0] op, input logic [3:0] rd, input logic dz, input int dwait);
        int cls, exp_wb, n_mul, n_div, n_fpu, n_abort, first_start;
        cls = model_class(op, dz);
        exp_wb = (cls == 0) ? 2 : (cls == 2) ? 2 + dwait : 1 + model_lat(op);
        n_mul = 0; n_div = 0; n_fpu = 0; n_abort = 0; first_start = -1;
        req_valid = 1'b1; req_op = op; req_rd = rd; div_zero = dz;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL accept_idle op=%b: ready=%b busy=%b, expected ready=1 busy=0", op, req_ready, busy);
        end
        step();
        req_valid = 1'b0;
        req_op = 4'($urandom);
        div_zero = 1'($urandom);
        for (int c = 1; c <= exp_wb + 1; c++) begin
            if (cls == 2) div_done = (c == 1 + dwait) || (c == 1 && 1'($urandom));
            else          div_done = 1'($urandom);
            @(negedge clk);
            if ((mul_start || div_start || fpu_start) && first_start < 0) first_start = c;
            n_mul += int'(mul_start); n_div += int'(div_start);
            n_fpu += int'(fpu_start); n_abort += int'(unit_abort);
            if (c == 1 && cls != 0) begin
                checks++;
                if (unit_op !== op[2:0]) begin
                    errors++;
                    $display("FAIL unit_op op=%b: got %b expected %b", op, unit_op, op[2:0]);
                end
            end
            checks++;
            if (busy !== (c <= exp_wb) || req_ready !== (c > exp_wb) || wb_valid !== (c == exp_wb)) begin
                errors++;
                $display("FAIL timing op=%b cyc=%0d: busy=%b ready=%b wb_valid=%b, expected wb at %0d",
                         op, c, busy, req_ready, wb_valid, exp_wb);
            end
            if (c == exp_wb) begin
                checks++;
                if (wb_rd !== rd || wb_src !== (op[3] ? 2'b10 : 2'b00) || wb_err !== (cls == 0)) begin
                    errors++;
                    $display("FAIL wb_fields op=%b: rd=%h src=%b err=%b, expected rd=%h src=%b err=%b",
                             op, wb_rd, wb_src, wb_err, rd, (op[3] ? 2'b10 : 2'b00), (cls == 0));
                end
            end
            step();
        end
        div_done = 1'b0;
        checks++;
        if (n_mul !== int'(cls == 1) || n_div !== int'(cls == 2) || n_fpu !== int'(cls == 3) || n_abort != 0
            || first_start !== ((cls == 0) ? -1 : 1)) begin
            errors++;
            $display("FAIL starts op=%b dz=%b: mul=%0d div=%0d fpu=%0d abort=%0d first=%0d",
                     op, dz, n_mul, n_div, n_fpu, n_abort, first_start);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (busy !== 1'b0 || wb_valid !== 1'b0 || unit_abort !== 1'b0 || req_ready !== 1'b0
            || mul_start !== 1'b0 || div_start !== 1'b0 || fpu_start !== 1'b0 || wb_rd !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b wb=%b abort=%b ready=%b starts=%b%b%b rd=%h, expected all 0",
                     busy, wb_valid, unit_abort, req_ready, mul_start, div_start, fpu_start, wb_rd);
        end
        repeat (2) step();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b, expected 1 0", req_ready, busy);
        end
        step();
    endtask

    task automatic test_directed();
        run_op(4'b0100, 4'd5, 1'b0, 0);
        run_op(4'b1001, 4'd9, 1'b0, 0);
        run_op(4'b0111, 4'd3, 1'b0, 12);
        run_op(4'b0111, 4'd7, 1'b1, 4);
        run_op(4'b0010, 4'd1, 1'b0, 0);
        run_op(4'b1010, 4'd14, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_op(4'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(1, 15)));
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic test_flush();
        int bad;
        // Flush two cycles into FADD: abort next cycle, no writeback.
        req_valid = 1'b1; req_op = 4'b1000; req_rd = 4'd6;
        step(); req_valid = 1'b0;
        step(); flush = 1'b1;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait_cycle: wb=%b ready=%b, expected 0 0", wb_valid, req_ready);
        end
        step(); flush = 1'b0;
        @(negedge clk);
        checks++;
        if (unit_abort !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_wait_after: abort=%b busy=%b ready=%b, expected 1 0 1", unit_abort, busy, req_ready);
        end
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            step(); @(negedge clk);
            if (wb_valid || unit_abort || fpu_start) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL flush_wait_quiet: %0d stray cycles, expected 0", bad);
        end
        // Flush in ISSUE suppresses the start pulse.
        step(); req_valid = 1'b1; req_op = 4'b0101;
        step(); req_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        checks++;
        if (mul_start !== 1'b0) begin
            errors++;
            $display("FAIL flush_issue_start: mul_start=%b expected 0", mul_start);
        end
        step(); flush = 1'b0;
        @(negedge clk);
        checks++;
        if (unit_abort !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_issue_abort: abort=%b busy=%b, expected 1 0", unit_abort, busy);
        end
        // Flush during WB keeps that writeback.
        step(); req_valid = 1'b1; req_op = 4'b1010; req_rd = 4'd11;
        step(); req_valid = 1'b0;
        step(); step(); flush = 1'b1;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== 4'd11 || wb_src !== 2'b10) begin
            errors++;
            $display("FAIL flush_in_wb: wb=%b rd=%h src=%b, expected 1 b 10", wb_valid, wb_rd, wb_src);
        end
        step(); flush = 1'b0;
        @(negedge clk);
        checks++;
        if (unit_abort !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_wb_after: abort=%b busy=%b wb=%b, expected 0 0 0", unit_abort, busy, wb_valid);
        end
        // Flush in IDLE blocks acceptance.
        step(); flush = 1'b1; req_valid = 1'b1; req_op = 4'b0100;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_ready: ready=%b expected 0", req_ready);
        end
        step(); flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mul_start !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_accept: busy=%b mul_start=%b, expected 0 0", busy, mul_start);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int bad;
        req_valid = 1'b1; req_op = 4'b1001; req_rd = 4'd2;
        step(); req_valid = 1'b0;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || wb_valid !== 1'b0 || unit_abort !== 1'b0 || fpu_start !== 1'b0
            || req_ready !== 1'b0 || unit_op !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid: busy=%b wb=%b abort=%b fpu=%b ready=%b uop=%b, expected all 0",
                     busy, wb_valid, unit_abort, fpu_start, req_ready, unit_op);
        end
        step(); reset = 1'b1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (wb_valid || unit_abort || busy || !req_ready) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_drop: %0d non-idle cycles, expected 0", bad);
        end
    endtask

`ifdef MCOP_DIV_TIMEOUT_EN
    task automatic test_div_timeout();
        int bad;
        bad = 0;
        req_valid = 1'b1; req_op = 4'b0111; req_rd = 4'd13; div_zero = 1'b0;
        step(); req_valid = 1'b0;
        for (int c = 1; c <= 43; c++) begin
            @(negedge clk);
            if (c == 42) begin
                checks++;
                if (wb_valid !== 1'b1 || wb_err !== 1'b1 || unit_abort !== 1'b1 || wb_rd !== 4'd13) begin
                    errors++;
                    $display("FAIL div_timeout: wb=%b err=%b abort=%b rd=%h, expected 1 1 1 d",
                             wb_valid, wb_err, unit_abort, wb_rd);
                end
            end else if (wb_valid || unit_abort) begin
                bad++;
            end
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL div_timeout_other: %0d stray cycles, expected 0", bad);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_random();
        test_reset_mid();
`ifdef MCOP_DIV_TIMEOUT_EN
        test_div_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
